cordic_vector: RTL

Iterative vectoring-mode CORDIC: the inverse direction of the team's pipelined rotation-mode CORDIC. It accepts a signed (X,Y) pair and returns the uncompensated magnitude K·sqrt(X²+Y²) and the angle atan2(Y,X). A single shared micro-rotation datapath is reused over 16 cycles under a start/busy/valid handshake. It uses the same 16-entry arctangent table, scaled 2^16 per radian, as the rotation core, so the two can be chained for polar↔rectangular round trips.

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_vec_iter.sv | 34 +++
 rtl/cordic_vector.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants and state type for the vectoring CORDIC
package cordic_pkg;

  localparam int IW    = 20;
  localparam int GUARD = 2;

  localparam logic signed [IW-1:0] PI_HALF_Q16 = 20'sd102944;
  localparam logic signed [IW-1:0] PI_Q313     = 20'sd25736;

  // atan(2^-i) scaled by 2^16 per radian; shared with the rotation-mode core
  localparam logic signed [IW-1:0] ATAN_TABLE [0:15] = '{
    20'sd51472, 20'sd30386, 20'sd16055, 20'sd8150,
    20'sd4091,  20'sd2047,  20'sd1024,  20'sd512,
    20'sd256,   20'sd128,   20'sd64,    20'sd32,
    20'sd16,    20'sd8,     20'sd4,     20'sd2
  };

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ITER, ST_DONE} state_e;

endpackage

// File: rtl/cordic_vec_iter.sv
// rtl/cordic_vec_iter.sv - one combinational vectoring micro-rotation
// Rotates toward the +X axis: the sign of Y picks the direction.
module cordic_vec_iter
  import cordic_pkg::*;
(
  input  logic signed [IW-1:0] x_i,
  input  logic signed [IW-1:0] y_i,
  input  logic signed [IW-1:0] z_i,
  input  logic [3:0]           shift_i,
  input  logic signed [IW-1:0] atan_i,
  output logic signed [IW-1:0] x_o,
  output logic signed [IW-1:0] y_o,
  output logic signed [IW-1:0] z_o
);

  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;

  assign x_sh = x_i >>> shift_i;
  assign y_sh = y_i >>> shift_i;

  always_comb begin
    if (!y_i[IW-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// rtl/cordic_vector.sv - iterative vectoring CORDIC: (X,Y) -> uncompensated magnitude and atan2 angle
// One shared micro-rotation stage is reused for ITER cycles under a start/busy/valid handshake.
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] Xin,
  input  logic [15:0] Yin,
  output logic        busy,
  output logic        valid,
  output logic [16:0] Mout,
  output logic [15:0] Zout
);

  localparam logic signed [IW-1:0] RND    = 20'sd4;
  localparam logic signed [IW-1:0] NEG_PI = -PI_Q313;

  state_e               state_q, state_d;
  logic [3:0]           iter_q, iter_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic                 zero_q, zero_d;
  logic [16:0]          mout_q, mout_d;
  logic [15:0]          zout_q, zout_d;

  logic signed [IW-1:0] x_n, y_n, z_n, mag, z_rnd, xin_ext, yin_ext;
  logic [16:0]          mag_fmt;
  logic [15:0]          z_fmt;
  logic                 last, accept;

  assign last    = (iter_q == 4'(ITER - 1));
  assign accept  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign xin_ext = {{(IW-16-GUARD){Xin[15]}}, Xin, {GUARD{1'b0}}};
  assign yin_ext = {{(IW-16-GUARD){Yin[15]}}, Yin, {GUARD{1'b0}}};

  cordic_vec_iter u_iter (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (iter_q),
    .atan_i  (ATAN_TABLE[iter_q]),
    .x_o     (x_n),
    .y_o     (y_n),
    .z_o     (z_n)
  );

  // Drop guard bits from X; Q16 angle to Q3.13 with round-half-up, clamped to [-pi, +pi]
  assign mag   = x_n >>> GUARD;
  assign z_rnd = (z_n + RND) >>> 3;

  always_comb begin
    mag_fmt = mag[16:0];
    if (mag[IW-1]) begin
      mag_fmt = '0;
    end else if (|mag[IW-2:17]) begin
      mag_fmt = '1;
    end
    z_fmt = z_rnd[15:0];
    if (z_rnd > PI_Q313) begin
      z_fmt = PI_Q313[15:0];
    end else if (z_rnd < NEG_PI) begin
      z_fmt = NEG_PI[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_ITER;
      ST_ITER: if (last) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_LOAD : ST_IDLE;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    iter_d = iter_q;
    zero_d = zero_q;
    mout_d = mout_q;
    zout_d = zout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          x_d    = xin_ext;
          y_d    = yin_ext;
          z_d    = '0;
          zero_d = (Xin == 16'd0) && (Yin == 16'd0);
        end
      end
      ST_LOAD: begin
        iter_d = '0;
        // Left half-plane: pre-rotate by +/-pi/2 so the iterations only cover [-pi/2, pi/2]
        if (x_q[IW-1]) begin
          if (!y_q[IW-1]) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = PI_HALF_Q16;
          end else begin
            x_d = -y_q;
            y_d = x_q;
            z_d = -PI_HALF_Q16;
          end
        end
      end
      ST_ITER: begin
        x_d    = x_n;
        y_d    = y_n;
        z_d    = z_n;
        iter_d = iter_q + 4'd1;
        if (last) begin
          iter_d = '0;
          mout_d = zero_q ? 17'd0 : mag_fmt;
          zout_d = zero_q ? 16'd0 : z_fmt;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      mout_q  <= '0;
      zout_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      mout_q  <= mout_d;
      zout_q  <= zout_d;
    end
  end

  assign busy  = (state_q == ST_LOAD) || (state_q == ST_ITER);
  assign valid = (state_q == ST_DONE);
  assign Mout  = mout_q;
  assign Zout  = zout_q;

endmodule
